// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C register-side blocks.
package i2c_pkg;

    localparam int I2C_ADDR_W = 8;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_VALID = 3'd2,
        ST_RD_DONE  = 3'd3,
        ST_WR_ACK   = 3'd4
    } regbank_state_t;

endpackage

// File: rtl/i2c_register_bank.sv
// Register bank behind the I2C peripheral: constant ID at address 0, read-only status mirrors,
// and R/W control registers, served over a read/ack and 4-phase write/ack handshake.
module i2c_register_bank
    import i2c_pkg::*;
#(
    parameter int                      NUM_REGS     = 16,
    parameter logic [7:0]              DEVICE_ID    = 8'hA5,
    parameter logic [NUM_REGS-1:0]     RO_MASK      = 16'h0002,
    parameter logic [NUM_REGS*8-1:0]   RESET_VALUES = '0,
    parameter int                      READ_LATENCY = 1,
    parameter logic [7:0]              OOR_DATA     = 8'hFF
) (
    input  logic                    i_sys_clk,
    input  logic                    i_rst_n,
    input  logic [I2C_ADDR_W-1:0]   i_register_address,
    input  logic                    i_read_enable,
    output logic [I2C_DATA_W-1:0]   o_register_data,
    output logic                    o_read_valid,
    input  logic                    i_read_ack,
    input  logic [I2C_DATA_W-1:0]   i_register_data,
    input  logic                    i_write_valid,
    output logic                    o_write_ack,
    input  logic [NUM_REGS*8-1:0]   i_status,
    output logic [NUM_REGS*8-1:0]   o_regs,
    output logic                    o_write_strobe,
    output logic [I2C_ADDR_W-1:0]   o_write_addr,
    output logic                    o_access_error,
    output regbank_state_t          o_state
);

    // Handshakes: a read is accepted in IDLE when i_read_enable=1 and answered by o_read_valid,
    // which holds with stable data until i_read_ack=1. A write is accepted in IDLE when
    // i_write_valid=1; o_write_ack rises and stays high until i_write_valid drops (4-phase).

    localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);
    localparam logic [255:0] RO_FULL = 256'(RO_MASK);

    function automatic logic in_range(input logic [I2C_ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    regbank_state_t        state_q, state_d;
    logic [3:0]            cnt_q;
    logic [I2C_ADDR_W-1:0] rd_addr_q;
    logic [7:0]            regs_q [NUM_REGS];

    logic do_write, do_rd_start, do_present, do_rd_clear, do_wr_release, cnt_dec;
    logic wr_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [7:0] rd_data;
    logic       rd_oor;

    assign o_state = state_q;
    assign wr_idx  = i_register_address[IDX_W-1:0];
    assign rd_idx  = rd_addr_q[IDX_W-1:0];
    assign wr_ok   = in_range(i_register_address) && (i_register_address != '0)
                     && !RO_FULL[i_register_address];

    // ID and read-only slots are never stored; they always show their live source.
    for (genvar n = 0; n < NUM_REGS; n++) begin : g_slot
        if (n == 0) begin : g_id
            assign o_regs[7:0] = DEVICE_ID;
        end else if (RO_MASK[n]) begin : g_ro
            assign o_regs[8*n +: 8] = i_status[8*n +: 8];
        end else begin : g_rw
            assign o_regs[8*n +: 8] = regs_q[n];
        end
    end

    always_comb begin
        rd_data = OOR_DATA;
        rd_oor  = 1'b1;
        if (in_range(rd_addr_q)) begin
            rd_oor = 1'b0;
            if (rd_addr_q == '0)
                rd_data = DEVICE_ID;
            else if (RO_FULL[rd_addr_q])
                rd_data = i_status[{rd_idx, 3'b000} +: 8];
            else
                rd_data = regs_q[rd_idx];
        end
    end

    always_comb begin
        state_d       = state_q;
        do_write      = 1'b0;
        do_rd_start   = 1'b0;
        do_present    = 1'b0;
        do_rd_clear   = 1'b0;
        do_wr_release = 1'b0;
        cnt_dec       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_write_valid) begin
                    do_write = 1'b1;
                    state_d  = ST_WR_ACK;
                end else if (i_read_enable) begin
                    do_rd_start = 1'b1;
                    state_d     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    do_present = 1'b1;
                    state_d    = ST_RD_VALID;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_VALID: begin
                if (i_read_ack) begin
                    do_rd_clear = 1'b1;
                    state_d     = ST_RD_DONE;
                end
            end
            ST_RD_DONE: begin
                // A still-asserted request for the same address was already served.
                if (!i_read_enable) begin
                    state_d = ST_IDLE;
                end else if (i_register_address != rd_addr_q) begin
                    do_rd_start = 1'b1;
                    state_d     = ST_RD_WAIT;
                end
            end
            ST_WR_ACK: begin
                if (!i_write_valid) begin
                    do_wr_release = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            rd_addr_q       <= '0;
            o_register_data <= '0;
            o_read_valid    <= 1'b0;
            o_write_ack     <= 1'b0;
            o_write_strobe  <= 1'b0;
            o_write_addr    <= '0;
            o_access_error  <= 1'b0;
            for (int n = 0; n < NUM_REGS; n++)
                regs_q[n] <= RESET_VALUES[8*n +: 8];
        end else begin
            state_q        <= state_d;
            o_write_strobe <= 1'b0;
            o_access_error <= 1'b0;
            if (do_write) begin
                o_write_ack <= 1'b1;
                if (wr_ok) begin
                    regs_q[wr_idx] <= i_register_data;
                    o_write_strobe <= 1'b1;
                    o_write_addr   <= i_register_address;
                end else begin
                    o_access_error <= 1'b1;
                end
            end
            if (do_wr_release)
                o_write_ack <= 1'b0;
            if (do_rd_start) begin
                rd_addr_q <= i_register_address;
                cnt_q     <= CNT_INIT;
            end
            if (cnt_dec)
                cnt_q <= cnt_q - 4'd1;
            if (do_present) begin
                o_register_data <= rd_data;
                o_read_valid    <= 1'b1;
                o_access_error  <= rd_oor;
            end
            if (do_rd_clear)
                o_read_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_register_bank.sv
// Randomized bench for i2c_register_bank checked against a register-array model of the bank.
module tb_i2c_register_bank;
    import i2c_pkg::*;

    localparam int NR = 16;
    localparam int RL = 3;
    localparam logic [127:0] RST_VALS = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [15:0]  RO_MSK   = 16'h0002;

    logic           sys_clk = 1'b0;
    logic           rst_n   = 1'b0;
    logic [7:0]     addr    = '0;
    logic           re      = 1'b0;
    logic [7:0]     rdata;
    logic           rvalid;
    logic           rack    = 1'b0;
    logic [7:0]     wdata   = '0;
    logic           we      = 1'b0;
    logic           wack;
    logic [127:0]   status  = '0;
    logic [127:0]   regs;
    logic           wstrobe;
    logic [7:0]     waddr;
    logic           aerr;
    regbank_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   m_regs [NR];
    logic [7:0]   m_last_waddr;
    logic [127:0] rst_vals_v;
    logic [15:0]  ro_v;

    i2c_register_bank #(
        .NUM_REGS(NR), .DEVICE_ID(8'hA5), .RO_MASK(RO_MSK),
        .RESET_VALUES(RST_VALS), .READ_LATENCY(RL), .OOR_DATA(8'hFF)
    ) dut (
        .i_sys_clk(sys_clk), .i_rst_n(rst_n),
        .i_register_address(addr), .i_read_enable(re),
        .o_register_data(rdata), .o_read_valid(rvalid), .i_read_ack(rack),
        .i_register_data(wdata), .i_write_valid(we), .o_write_ack(wack),
        .i_status(status), .o_regs(regs), .o_write_strobe(wstrobe),
        .o_write_addr(waddr), .o_access_error(aerr), .o_state(dbg_state)
    );

    // clock
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic writable(input logic [7:0] a);
        return (int'(a) < NR) && (a != 8'd0) && !ro_v[a[3:0]];
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a);
        if (int'(a) >= NR) return 8'hFF;
        if (a == 8'd0)     return 8'hA5;
        if (ro_v[a[3:0]])  return status[8*a[3:0] +: 8];
        return m_regs[a[3:0]];
    endfunction

    function automatic logic [127:0] exp_regs();
        logic [127:0] v;
        for (int n = 0; n < NR; n++)
            v[8*n +: 8] = exp_read(8'(n));
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NR; n++)
            m_regs[n] = rst_vals_v[8*n +: 8];
        m_last_waddr = 8'd0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        logic ok;
        int   hold;
        ok    = writable(a);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        if (ok) begin
            m_regs[a[3:0]] = d;
            m_last_waddr   = a;
        end
        check("wr_ack", wack, 1'b1);
        check("wr_strobe", wstrobe, ok);
        check("wr_err", aerr, !ok);
        check("wr_addr", waddr, m_last_waddr);
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("wr_ack_hold", wack, 1'b1);
            check("wr_strobe_once", wstrobe, 1'b0);
        end
        we = 1'b0;
        tick();
        check("wr_ack_drop", wack, 1'b0);
        check("wr_regs", regs, exp_regs());
    endtask

    // Called just after the accept edge; ends right after the ack edge.
    task automatic finish_read(input logic [7:0] exp_d, input logic exp_err);
        int lat = 0;
        int hold;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("rd_latency", lat, RL);
        check("rd_data", rdata, exp_d);
        check("rd_err", aerr, exp_err);
        hold = $urandom_range(0, 3);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rd_valid_hold", rvalid, 1'b1);
            check("rd_data_hold", rdata, exp_d);
            check("rd_err_once", aerr, 1'b0);
        end
        rack = 1'b1;
        tick();
        rack = 1'b0;
        check("rd_valid_drop", rvalid, 1'b0);
        check("rd_data_keep", rdata, exp_d);
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [7:0] e;
        e    = exp_read(a);
        addr = a;
        re   = 1'b1;
        tick();
        re = 1'b0;
        finish_read(e, int'(a) >= NR);
        tick();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] a;
        int lat;
        rst_vals_v = RST_VALS;
        ro_v       = RO_MSK;
        status     = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_reset();

        // reset state
        repeat (2) tick();
        check("rst_rdata", rdata, 8'h00);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_wack", wack, 1'b0);
        check("rst_strobe", wstrobe, 1'b0);
        check("rst_waddr", waddr, 8'h00);
        check("rst_err", aerr, 1'b0);
        check("rst_regs", regs, exp_regs());
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // directed cases
        do_write(8'h03, 8'h55);
        check("reg3_slot", regs[31:24], 8'h55);
        do_read(8'h03);
        do_read(8'h00);
        do_write(8'h00, 8'h12);
        do_write(8'h01, 8'h12);
        do_read(8'h00);
        do_read(8'h01);
        do_read(8'h40);
        do_write(8'h40, 8'h77);

        // simultaneous read and write: write commits first, read follows
        d = 8'(($urandom_range(0, 255)));
        addr = 8'h07; wdata = d; we = 1'b1; re = 1'b1;
        tick();
        m_regs[7] = d;
        m_last_waddr = 8'h07;
        check("sim_wack", wack, 1'b1);
        check("sim_strobe", wstrobe, 1'b1);
        tick();
        check("sim_no_read", rvalid, 1'b0);
        we = 1'b0;
        tick();
        check("sim_wack_drop", wack, 1'b0);
        tick();
        re = 1'b0;
        finish_read(d, 1'b0);
        tick();

        // held request: no re-read of same address, new address starts a new read
        addr = 8'h03; re = 1'b1;
        tick();
        finish_read(exp_read(8'h03), 1'b0);
        repeat (5) tick();
        check("no_reread", rvalid, 1'b0);
        addr = 8'h05;
        tick();
        re = 1'b0;
        finish_read(exp_read(8'h05), 1'b0);
        tick();

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            status = {$urandom(), $urandom(), $urandom(), $urandom()};
            a = 8'($urandom_range(0, NR + 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, 8'($urandom_range(0, 255)));
            else
                do_read(a);
        end

        // reset asserted while a read is being presented
        addr = 8'h02; re = 1'b1;
        tick();
        re = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check("pre_rst_valid", rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_rdata", rdata, 8'h00);
        check("mid_rst_wack", wack, 1'b0);
        check("mid_rst_waddr", waddr, 8'h00);
        check("mid_rst_err", aerr, 1'b0);
        check("mid_rst_regs", regs, exp_regs());
        check("mid_rst_state", dbg_state, ST_IDLE);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(8'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
